column_pixel_responder: RTL and testbench
=========================================

# column_pixel_responder

Responder end of the column-write handshake used by the heat-map plotter: one instance per screen column, selected by one bit of the plotter's column-select bus. On a select it stores an 8-bit pixel at the requested row in a private M10K column buffer, then returns an acknowledge that the plotter waits on before releasing the select. A second, independent port streams pixels out to the VGA driver. A bulk-clear sequencer blanks the column between frames.

## Interface
- ROWS, 480, number of rows stored (valid row indices 0..ROWS-1)
- ROW_W, 10, width of row indices
- PIX_W, 8, pixel width
- CLEAR_VAL, 8'h00, value written by a bulk clear
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  reset, synchronous, active-high
- sel  in  1  this column's bit of the plotter column-select bus
- row  in  ROW_W  target row; sampled when sel is first seen high
- color  in  PIX_W  pixel value; sampled with row
- ret  out  1  acknowledge (this column's bit of the return bus)
- clear_req  in  1  single-cycle pulse requesting a column blank
- busy  out  1  high while a clear is in progress
- vga_rd_en  in  1  VGA read strobe
- vga_row  in  ROW_W  VGA read row
- vga_pixel  out  PIX_W  pixel read back
- vga_valid  out  1  vga_pixel is valid this cycle

## Operation
- FSM states: IDLE, WRITE, ACK, CLEAR.
- IDLE: clear_req seen -> CLEAR, clear counter = 0. Otherwise sel high -> latch row/color -> WRITE. clear_req takes priority when both are seen on the same cycle; the select then waits until the clear finishes.
- WRITE: one M10K write of the latched color at the latched row. A row >= ROWS suppresses the write but still goes to ACK, so the plotter never hangs. -> ACK.
- ACK: ret = 1 and held. When sel is seen low, drop ret the next cycle -> IDLE. A plotter that re-asserts sel while ret is high causes no second write.
- CLEAR: write CLEAR_VAL at counter, counter++ each cycle. After row ROWS-1 is written -> IDLE. busy = 1 for the whole state. sel arriving during CLEAR is not acknowledged until the clear finishes. clear_req arriving in WRITE/ACK is latched as pending and serviced on the next entry to IDLE.
- VGA port is independent of the FSM:
  - vga_rd_en at cycle N -> vga_pixel/vga_valid at N+2.
  - vga_row >= ROWS returns 0 with valid still asserted.
- Read during a write to the same row returns the old data (M10K old-data behaviour).

## Timing
- Reset values: ret=0, busy=0, vga_valid=0, vga_pixel=0, FSM=IDLE, clear pending=0.
- Memory contents are not touched by reset and are undefined until a clear or write.
- Reset mid-handshake or mid-clear aborts it. ret and busy are low the cycle after reset.
- sel rises at cycle N -> write at N+1 -> ret high at N+2.
- sel low seen at M -> ret low at M+1 -> next select accepted from M+1.
- Minimum full handshake: 4 cycles.
- Clear: busy rises the cycle after clear_req and lasts ROWS cycles (480).
- VGA reads are fully pipelined: one per cycle, throughput 1.

## Structure
- Shared package heatmap_pkg holds ROWS, COLS (64), ROW_W, PIX_W, CLEAR_VAL and the FSM state encoding; the plotter uses the same package.
- Sub-module M10K_512_8: simple dual-port, registered read (1-cycle q), one write port shared by the WRITE and CLEAR paths through a mux, one read port owned by VGA.
- The top level instantiates COLS copies of this block via generate, wiring col_select[i] to sel and return_sig[i] to ret.

## Test plan
- Reset, then a clear pulse -> busy high for exactly 480 cycles. VGA reads of rows 0, 239 and 479 then return 8'h00.
- sel with row=17, color=8'hFF, released 1 cycle after ret -> ret high at N+2 and low the cycle after sel drops. A VGA read of row 17 returns 8'hFF at +2 cycles.
- Plotter-style retry: sel toggled high/low/high before ret, then held until ret -> exactly one write. A VGA read returns the last latched color.
- row=600 (out of range) -> ret still asserts, no memory change. A VGA read of row 600 returns 0 with vga_valid=1.
- clear_req and sel rising on the same cycle -> clear runs first with ret=0 throughout. ret asserts 2 cycles after busy falls, and the written pixel survives.
- Continuous VGA reads of rows 0..479 while a write to row 5 lands -> one pixel per cycle with no gaps. The read of row 5 issued in the write cycle returns old data; a later read returns the new data.

Source files
------------

// File: rtl/heatmap_pkg.sv
// Shared constants for the heat-map plotter and its per-column responders.
package heatmap_pkg;

  localparam int unsigned ROWS   = 480;
  localparam int unsigned COLS   = 64;
  localparam int unsigned ROW_W  = 10;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 9;

  localparam logic [PIX_W-1:0] CLEAR_VAL = 8'h00;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [PIX_W-1:0] color;
  } pix_req_t;

endpackage

// File: rtl/M10K_512_8.sv
// Simple dual-port 512x8 column buffer with registered read; same-address
// read during write returns the old contents.
module M10K_512_8
  import heatmap_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  q
);

  logic [PIX_W-1:0] mem [512];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    q <= mem[raddr];
  end

endmodule

// File: rtl/column_pixel_responder.sv
// One screen column: accepts plotter pixel writes over a sel/ret handshake,
// blanks the column on request, and serves a pipelined VGA read port.
module column_pixel_responder
  import heatmap_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             sel,
  input  logic [ROW_W-1:0] row,
  input  logic [PIX_W-1:0] color,
  output logic             ret,
  input  logic             clear_req,
  output logic             busy,
  input  logic             vga_rd_en,
  input  logic [ROW_W-1:0] vga_row,
  output logic [PIX_W-1:0] vga_pixel,
  output logic             vga_valid
);

  logic [1:0]       state_q, state_d;
  logic             ret_q, ret_d;
  logic             busy_q, busy_d;
  logic             pend_q, pend_d;
  logic [ROW_W-1:0] cnt_q, cnt_d;
  pix_req_t         req_q, req_d;

  logic              we_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [PIX_W-1:0]  wdata_c;
  logic [PIX_W-1:0]  mem_q;

  logic             rd1_q, rd1_d;
  logic             oor1_q, oor1_d;
  logic             vga_valid_q, vga_valid_d;
  logic [PIX_W-1:0] vga_pixel_q, vga_pixel_d;

  // Handshake / clear sequencer; the write port is shared by WRITE and CLEAR.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_c    = 1'b0;
    waddr_c = '0;
    wdata_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req || pend_q) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
        end else if (sel) begin
          req_d.row   = row;
          req_d.color = color;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (clear_req) pend_d = 1'b1;
        // Out-of-range rows are dropped but still acknowledged.
        we_c    = (req_q.row < ROW_W'(ROWS));
        waddr_c = req_q.row[ADDR_W-1:0];
        wdata_c = req_q.color;
        ret_d   = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (clear_req) pend_d = 1'b1;
        if (!sel) begin
          ret_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        we_c    = 1'b1;
        waddr_c = cnt_q[ADDR_W-1:0];
        wdata_c = CLEAR_VAL;
        cnt_d   = cnt_q + ROW_W'(1);
        if (cnt_q == ROW_W'(ROWS - 1)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ret_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Two-stage VGA read: RAM output register, then range-masked output register.
  always_comb begin
    rd1_d       = vga_rd_en;
    oor1_d      = (vga_row >= ROW_W'(ROWS));
    vga_valid_d = rd1_q;
    vga_pixel_d = (rd1_q && !oor1_q) ? mem_q : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ret_q       <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      req_q       <= '0;
      rd1_q       <= 1'b0;
      oor1_q      <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rd1_q       <= rd1_d;
      oor1_q      <= oor1_d;
      vga_valid_q <= vga_valid_d;
      vga_pixel_q <= vga_pixel_d;
    end
  end

  M10K_512_8 u_mem (
    .clock (clock),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (wdata_c),
    .raddr (vga_row[ADDR_W-1:0]),
    .q     (mem_q)
  );

  assign ret       = ret_q;
  assign busy      = busy_q;
  assign vga_pixel = vga_pixel_q;
  assign vga_valid = vga_valid_q;

endmodule

// File: tb/tb_column_pixel_responder.sv
// Directed self-checking bench for column_pixel_responder.
module tb_column_pixel_responder;

  logic       clock, reset, sel, clear_req, vga_rd_en;
  logic [9:0] row, vga_row;
  logic [7:0] color, vga_pixel;
  logic       ret, busy, vga_valid;

  int n_checks = 0;
  int n_fail   = 0;

  column_pixel_responder dut (
    .clock     (clock),
    .reset     (reset),
    .sel       (sel),
    .row       (row),
    .color     (color),
    .ret       (ret),
    .clear_req (clear_req),
    .busy      (busy),
    .vga_rd_en (vga_rd_en),
    .vga_row   (vga_row),
    .vga_pixel (vga_pixel),
    .vga_valid (vga_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one read and returns valid one cycle early, then pixel/valid at +2.
  task automatic vga_read(input logic [9:0] r, output logic [7:0] pix,
                          output logic vld, output logic vld_early);
    vga_rd_en = 1'b1;
    vga_row   = r;
    tick();
    vga_rd_en = 1'b0;
    vld_early = vga_valid;
    tick();
    pix = vga_pixel;
    vld = vga_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (ret !== 1'b0) begin n_fail++; $display("FAIL reset_ret got %b exp 0", ret); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (vga_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", vga_valid); end
    n_checks++; if (vga_pixel !== 8'h00) begin n_fail++; $display("FAIL reset_pixel got %h exp 00", vga_pixel); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    int cnt;
    logic [7:0] pix;
    logic vld, vld_e;
    logic [9:0] rows [3];
    rows[0] = 10'd0; rows[1] = 10'd239; rows[2] = 10'd479;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 600) begin cnt++; tick(); end
    n_checks++; if (cnt != 480) begin n_fail++; $display("FAIL clear_busy_len got %0d exp 480", cnt); end
    for (int i = 0; i < 3; i++) begin
      vga_read(rows[i], pix, vld, vld_e);
      n_checks++;
      if (pix !== 8'h00 || vld !== 1'b1) begin
        n_fail++; $display("FAIL clear_read row %0d got %h/%b exp 00/1", rows[i], pix, vld);
      end
    end
  endtask

  task automatic test_write();
    logic [7:0] pix;
    logic vld, vld_e;
    sel = 1'b1; row = 10'd17; color = 8'hFF;
    tick();
    n_checks++; if (ret !== 1'b0) begin n_fail++; $display("FAIL write_ret_n1 got %b exp 0", ret); end
    tick();
    n_checks++; if (ret !== 1'b1) begin n_fail++; $display("FAIL write_ret_n2 got %b exp 1", ret); end
    tick();
    n_checks++; if (ret !== 1'b1) begin n_fail++; $display("FAIL write_ret_hold got %b exp 1", ret); end
    sel = 1'b0;
    tick();
    n_checks++; if (ret !== 1'b0) begin n_fail++; $display("FAIL write_ret_drop got %b exp 0", ret); end
    vga_read(10'd17, pix, vld, vld_e);
    n_checks++; if (vld_e !== 1'b0) begin n_fail++; $display("FAIL write_read_early_valid got %b exp 0", vld_e); end
    n_checks++; if (pix !== 8'hFF || vld !== 1'b1) begin n_fail++; $display("FAIL write_read got %h/%b exp ff/1", pix, vld); end
  endtask

  task automatic test_retry();
    logic [7:0] pix;
    logic vld, vld_e;
    sel = 1'b1; row = 10'd30; color = 8'h5A;
    tick();
    sel = 1'b0; color = 8'hA5;
    tick();
    sel = 1'b1; color = 8'h3C;
    n_checks++; if (ret !== 1'b1) begin n_fail++; $display("FAIL retry_ret got %b exp 1", ret); end
    repeat (3) tick();
    n_checks++; if (ret !== 1'b1) begin n_fail++; $display("FAIL retry_ret_held got %b exp 1", ret); end
    sel = 1'b0;
    tick();
    n_checks++; if (ret !== 1'b0) begin n_fail++; $display("FAIL retry_ret_drop got %b exp 0", ret); end
    vga_read(10'd30, pix, vld, vld_e);
    n_checks++; if (pix !== 8'h5A || vld !== 1'b1) begin n_fail++; $display("FAIL retry_read got %h/%b exp 5a/1", pix, vld); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] pix;
    logic vld, vld_e;
    sel = 1'b1; row = 10'd600; color = 8'h77;
    tick();
    tick();
    n_checks++; if (ret !== 1'b1) begin n_fail++; $display("FAIL oor_ret got %b exp 1", ret); end
    sel = 1'b0;
    tick();
    n_checks++; if (ret !== 1'b0) begin n_fail++; $display("FAIL oor_ret_drop got %b exp 0", ret); end
    vga_read(10'd88, pix, vld, vld_e);
    n_checks++; if (pix !== 8'h00 || vld !== 1'b1) begin n_fail++; $display("FAIL oor_alias_row88 got %h/%b exp 00/1", pix, vld); end
    vga_read(10'd600, pix, vld, vld_e);
    n_checks++; if (pix !== 8'h00 || vld !== 1'b1) begin n_fail++; $display("FAIL oor_read600 got %h/%b exp 00/1", pix, vld); end
  endtask

  task automatic test_clear_priority();
    int cnt, ret_bad;
    logic [7:0] pix;
    logic vld, vld_e;
    clear_req = 1'b1; sel = 1'b1; row = 10'd100; color = 8'hC3;
    tick();
    clear_req = 1'b0;
    cnt = 0; ret_bad = 0;
    while (busy === 1'b1 && cnt < 600) begin
      if (ret !== 1'b0) ret_bad++;
      cnt++;
      tick();
    end
    n_checks++; if (cnt != 480) begin n_fail++; $display("FAIL prio_busy_len got %0d exp 480", cnt); end
    n_checks++; if (ret_bad != 0) begin n_fail++; $display("FAIL prio_ret_during_clear got %0d high cycles exp 0", ret_bad); end
    n_checks++; if (ret !== 1'b0) begin n_fail++; $display("FAIL prio_ret_f0 got %b exp 0", ret); end
    tick();
    n_checks++; if (ret !== 1'b0) begin n_fail++; $display("FAIL prio_ret_f1 got %b exp 0", ret); end
    tick();
    n_checks++; if (ret !== 1'b1) begin n_fail++; $display("FAIL prio_ret_f2 got %b exp 1", ret); end
    sel = 1'b0;
    tick();
    vga_read(10'd100, pix, vld, vld_e);
    n_checks++; if (pix !== 8'hC3 || vld !== 1'b1) begin n_fail++; $display("FAIL prio_read got %h/%b exp c3/1", pix, vld); end
  endtask

  task automatic test_pending_clear();
    int cnt;
    logic [7:0] pix;
    logic vld, vld_e;
    sel = 1'b1; row = 10'd5; color = 8'h11;
    tick();
    tick();
    sel = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n_checks++; if (ret !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL pend_idle got ret %b busy %b exp 0/0", ret, busy); end
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pend_busy_start got %b exp 1", busy); end
    cnt = 0;
    while (busy === 1'b1 && cnt < 600) begin cnt++; tick(); end
    n_checks++; if (cnt != 480) begin n_fail++; $display("FAIL pend_busy_len got %0d exp 480", cnt); end
    vga_read(10'd5, pix, vld, vld_e);
    n_checks++; if (pix !== 8'h00 || vld !== 1'b1) begin n_fail++; $display("FAIL pend_read got %h/%b exp 00/1", pix, vld); end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    logic [7:0] pix;
    logic vld, vld_e;
    nvalid = 0;
    for (int i = 0; i < 482; i++) begin
      vga_rd_en = (i < 480);
      vga_row   = 10'(i);
      if (i == 4) begin sel = 1'b1; row = 10'd5; color = 8'hE7; end
      if (i == 6) begin
        n_checks++; if (ret !== 1'b1) begin n_fail++; $display("FAIL stream_ret got %b exp 1", ret); end
        sel = 1'b0;
      end
      if (i == 7) begin
        n_checks++; if (ret !== 1'b0) begin n_fail++; $display("FAIL stream_ret_drop got %b exp 0", ret); end
      end
      if (i >= 2) begin
        if (vga_valid === 1'b1) nvalid++;
        n_checks++;
        if (vga_pixel !== 8'h00) begin
          n_fail++; $display("FAIL stream_pixel row %0d got %h exp 00", i - 2, vga_pixel);
        end
      end
      tick();
    end
    vga_rd_en = 1'b0;
    n_checks++; if (nvalid != 480) begin n_fail++; $display("FAIL stream_valid_count got %0d exp 480", nvalid); end
    vga_read(10'd5, pix, vld, vld_e);
    n_checks++; if (pix !== 8'hE7 || vld !== 1'b1) begin n_fail++; $display("FAIL stream_new_data got %h/%b exp e7/1", pix, vld); end
  endtask

  task automatic test_reset_abort();
    sel = 1'b1; row = 10'd9; color = 8'h42;
    tick();
    tick();
    n_checks++; if (ret !== 1'b1) begin n_fail++; $display("FAIL abort_ret_pre got %b exp 1", ret); end
    reset = 1'b1; sel = 1'b0;
    tick();
    n_checks++; if (ret !== 1'b0) begin n_fail++; $display("FAIL abort_ret got %b exp 0", ret); end
    reset = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (5) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_pre got %b exp 1", busy); end
    reset = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
    reset = 1'b0;
    repeat (2) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_stays got %b exp 0", busy); end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; clear_req = 1'b0; vga_rd_en = 1'b0;
    row = '0; vga_row = '0; color = '0;
    test_reset();
    test_clear();
    test_write();
    test_retry();
    test_out_of_range();
    test_clear_priority();
    test_pending_clear();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
